// File: rtl/image_downsample_2x.sv
// -----------------------------------------------------------------------------
// image_downsample_2x
//
// Purpose:
//   Builds the half-resolution base image for the next Gaussian-pyramid octave.
//   On a start pulse it walks every even (x, y) pixel of the source plane held
//   in a single-port read-first BRAM and writes those pixels, densely packed
//   and bit-exact, into a destination BRAM at one pixel per cycle. The source
//   BRAM read latency is a parameter (1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE).
//
// Ports:
//   clk_in       in   system clock, single domain
//   rst_in       in   synchronous reset, active-low
//   start_in     in   start a pass (accepted only while idle)
//   rd_addr_out  out  source BRAM address
//   rd_en_out    out  source BRAM enable
//   rd_data_in   in   source BRAM read data
//   wr_addr_out  out  destination BRAM address
//   wr_en_out    out  destination BRAM write enable
//   wr_data_out  out  destination BRAM write data
//   busy_out     out  high while reading or draining
//   done_out     out  one-cycle pulse at the end of a completed pass
// -----------------------------------------------------------------------------
module image_downsample_2x #(
  parameter int SRC_WIDTH    = 64,
  parameter int SRC_HEIGHT   = 64,
  parameter int BIT_DEPTH    = 8,
  parameter int READ_LATENCY = 2,
  localparam int RA_W  = $clog2(SRC_WIDTH * SRC_HEIGHT),
  localparam int N_PIX = (SRC_WIDTH / 2) * (SRC_HEIGHT / 2),
  // A 2x2 source yields a single destination pixel; keep the port 1 bit wide.
  localparam int WA_W  = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  output logic [RA_W-1:0]      rd_addr_out,
  output logic                 rd_en_out,
  input  logic [BIT_DEPTH-1:0] rd_data_in,
  output logic [WA_W-1:0]      wr_addr_out,
  output logic                 wr_en_out,
  output logic [BIT_DEPTH-1:0] wr_data_out,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int DR_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [RA_W-1:0] SX_LAST  = RA_W'(SRC_WIDTH - 2);
  localparam logic [RA_W-1:0] SY_LAST  = RA_W'(SRC_HEIGHT - 2);
  localparam logic [RA_W-1:0] COL_STEP = RA_W'(2);
  // Wrapping sx from SRC_WIDTH-2 back to 0 while sy advances by 2 moves the
  // linear address forward by 2*SRC_WIDTH - (SRC_WIDTH-2) = SRC_WIDTH + 2.
  localparam logic [RA_W-1:0] ROW_STEP = RA_W'(SRC_WIDTH + 2);
  localparam logic [DR_W-1:0] DR_LAST  = DR_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                  state_q;
  logic [RA_W-1:0]         sx_q;
  logic [RA_W-1:0]         sy_q;
  logic [RA_W-1:0]         rd_addr_q;
  logic                    rd_en_q;
  logic                    busy_q;
  logic                    done_q;
  logic [DR_W-1:0]         drain_q;
  logic [READ_LATENCY-1:0] vld_q;
  logic [WA_W-1:0]         dest_q;
  logic [WA_W-1:0]         wr_addr_q;
  logic [BIT_DEPTH-1:0]    wr_data_q;
  logic                    tap;

  // The valid bit that left rd_en_out READ_LATENCY cycles ago marks the cycle
  // in which the BRAM presents that read's data.
  assign tap = vld_q[READ_LATENCY-1];

  // NOTE: reset is sampled only on the clock edge, so it lives inside the
  // clocked block and is not in the sensitivity list.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      sx_q      <= '0;
      sy_q      <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drain_q   <= '0;
      vld_q     <= '0;
      dest_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register below see the
      // values from before this edge, independent of statement order.
      vld_q[0] <= rd_en_q;
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
      end

      // Remember the last write so the write port holds steady between writes.
      if (tap) begin
        wr_addr_q <= dest_q;
        wr_data_q <= rd_data_in;
        dest_q    <= dest_q + WA_W'(1);
      end

      unique case (state_q)
        S_IDLE: begin
          if (start_in) begin
            state_q   <= S_READ;
            sx_q      <= '0;
            sy_q      <= '0;
            dest_q    <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b1;
            busy_q    <= 1'b1;
          end
        end

        S_READ: begin
          if (sx_q == SX_LAST) begin
            sx_q <= '0;
            if (sy_q == SY_LAST) begin
              state_q   <= S_DRAIN;
              rd_en_q   <= 1'b0;
              rd_addr_q <= '0;
              drain_q   <= '0;
            end else begin
              sy_q      <= sy_q + COL_STEP;
              rd_addr_q <= rd_addr_q + ROW_STEP;
            end
          end else begin
            sx_q      <= sx_q + COL_STEP;
            rd_addr_q <= rd_addr_q + COL_STEP;
          end
        end

        // Wait out the read latency so the last issued read reaches the
        // destination before done is reported.
        S_DRAIN: begin
          if (drain_q == DR_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + DR_W'(1);
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_addr_out = rd_addr_q;
  assign rd_en_out   = rd_en_q;
  assign busy_out    = busy_q;
  assign done_out    = done_q;

  // Write port is driven straight from the tap and the BRAM data.
  assign wr_en_out   = tap;
  assign wr_addr_out = tap ? dest_q : wr_addr_q;
  assign wr_data_out = tap ? rd_data_in : wr_data_q;

endmodule

// File: tb/tb_image_downsample_2x.sv
// -----------------------------------------------------------------------------
// tb_image_downsample_2x
//
// Three instances share one clock:
//   a: 4x4 source, read latency 2, src[a] = a
//   b: 4x4 source, read latency 1, src[a] = a
//   c: 8x6 source, read latency 2, src[a] = a ^ 8'h5A
// Each source BRAM is a small behavioural model. Every accepted start pushes
// the expected reads, writes, done pulse and busy window; a negedge monitor
// pops and compares them cycle by cycle.
// -----------------------------------------------------------------------------
module tb_image_downsample_2x;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } ev_t;

  logic       clk;
  logic [2:0] rst_v;
  logic [2:0] start_v;
  int         cyc;
  bit         mon_en;
  int         n_cmp;
  int         n_bad;

  ev_t rd_q   [3][$];
  ev_t wr_q   [3][$];
  int  done_q [3][$];
  int  busy_lo [3];
  int  busy_hi [3];

  int    img_w   [3] = '{4, 4, 8};
  int    img_h   [3] = '{4, 4, 6};
  int    img_l   [3] = '{2, 1, 2};
  int    img_x   [3] = '{0, 0, 'h5A};
  string img_nm  [3] = '{"a4x4", "b4x4l1", "c8x6"};

  // Instance a
  logic [3:0] a_rd_addr;
  logic       a_rd_en;
  logic [7:0] a_rd_data, a_q1, a_q2;
  logic [1:0] a_wr_addr;
  logic       a_wr_en;
  logic [7:0] a_wr_data;
  logic       a_busy, a_done;

  // Instance b
  logic [3:0] b_rd_addr;
  logic       b_rd_en;
  logic [7:0] b_rd_data, b_q1;
  logic [1:0] b_wr_addr;
  logic       b_wr_en;
  logic [7:0] b_wr_data;
  logic       b_busy, b_done;

  // Instance c
  logic [5:0] c_rd_addr;
  logic       c_rd_en;
  logic [7:0] c_rd_data, c_q1, c_q2;
  logic [3:0] c_wr_addr;
  logic       c_wr_en;
  logic [7:0] c_wr_data;
  logic       c_busy, c_done;

  image_downsample_2x #(.SRC_WIDTH(4), .SRC_HEIGHT(4), .BIT_DEPTH(8), .READ_LATENCY(2)) u_dut_a (
    .clk_in(clk), .rst_in(rst_v[0]), .start_in(start_v[0]),
    .rd_addr_out(a_rd_addr), .rd_en_out(a_rd_en), .rd_data_in(a_rd_data),
    .wr_addr_out(a_wr_addr), .wr_en_out(a_wr_en), .wr_data_out(a_wr_data),
    .busy_out(a_busy), .done_out(a_done)
  );

  image_downsample_2x #(.SRC_WIDTH(4), .SRC_HEIGHT(4), .BIT_DEPTH(8), .READ_LATENCY(1)) u_dut_b (
    .clk_in(clk), .rst_in(rst_v[1]), .start_in(start_v[1]),
    .rd_addr_out(b_rd_addr), .rd_en_out(b_rd_en), .rd_data_in(b_rd_data),
    .wr_addr_out(b_wr_addr), .wr_en_out(b_wr_en), .wr_data_out(b_wr_data),
    .busy_out(b_busy), .done_out(b_done)
  );

  image_downsample_2x #(.SRC_WIDTH(8), .SRC_HEIGHT(6), .BIT_DEPTH(8), .READ_LATENCY(2)) u_dut_c (
    .clk_in(clk), .rst_in(rst_v[2]), .start_in(start_v[2]),
    .rd_addr_out(c_rd_addr), .rd_en_out(c_rd_en), .rd_data_in(c_rd_data),
    .wr_addr_out(c_wr_addr), .wr_en_out(c_wr_en), .wr_data_out(c_wr_data),
    .busy_out(c_busy), .done_out(c_done)
  );

  // Source BRAM models: enable-gated first stage, output register always
  // enabled (regcea tied high) for the two-cycle variants.
  always @(posedge clk) begin
    if (a_rd_en) a_q1 <= 8'(a_rd_addr);
    a_q2 <= a_q1;
    if (b_rd_en) b_q1 <= 8'(b_rd_addr);
    if (c_rd_en) c_q1 <= 8'(c_rd_addr) ^ 8'h5A;
    c_q2 <= c_q1;
  end
  assign a_rd_data = a_q2;
  assign b_rd_data = b_q1;
  assign c_rd_data = c_q2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic string tg(input int id, input string s);
    return $sformatf("%s_%s", img_nm[id], s);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected traffic of one pass whose first read cycle is t0.
  task automatic push_pass(input int id, input int t0);
    int k;
    int a;
    k = 0;
    for (int j = 0; j < img_h[id] / 2; j++) begin
      for (int i = 0; i < img_w[id] / 2; i++) begin
        a = 2 * j * img_w[id] + 2 * i;
        rd_q[id].push_back('{t0 + k, a, 0});
        wr_q[id].push_back('{t0 + k + img_l[id], k, (a ^ img_x[id]) & 255});
        k++;
      end
    end
    done_q[id].push_back(t0 + k + img_l[id]);
    busy_lo[id] = t0;
    busy_hi[id] = t0 + k + img_l[id] - 1;
  endtask

  // Pulse start for one cycle from an idle DUT; returns the first READ cycle.
  task automatic start_pass(input int id, output int t0);
    start_v[id] = 1'b1;
    t0 = cyc + 1;
    push_pass(id, t0);
    tick(1);
    start_v[id] = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    int b;
    b = 0;
    while ((rd_q[id].size() + wr_q[id].size() + done_q[id].size()) > 0 && b < 500) begin
      tick(1);
      b++;
    end
    check(tg(id, "pass_complete"), 32'(b < 500), 1);
    tick(1);
  endtask

  task automatic mon(input int id, input logic rd_en, input logic [31:0] rd_addr,
                     input logic wr_en, input logic [31:0] wr_addr,
                     input logic [31:0] wr_data, input logic done, input logic busy);
    ev_t e;
    bit  exp_rd, exp_wr, exp_done;
    exp_rd   = rd_q[id].size() > 0 && rd_q[id][0].cyc == cyc;
    exp_wr   = wr_q[id].size() > 0 && wr_q[id][0].cyc == cyc;
    exp_done = done_q[id].size() > 0 && done_q[id][0] == cyc;
    check(tg(id, "rd_en"), 32'(rd_en), 32'(exp_rd));
    if (exp_rd) begin
      e = rd_q[id].pop_front();
      if (rd_en === 1'b1) check(tg(id, "rd_addr"), rd_addr, e.addr);
    end
    check(tg(id, "wr_en"), 32'(wr_en), 32'(exp_wr));
    if (exp_wr) begin
      e = wr_q[id].pop_front();
      if (wr_en === 1'b1) begin
        check(tg(id, "wr_addr"), wr_addr, e.addr);
        check(tg(id, "wr_data"), wr_data, e.data);
      end
    end
    check(tg(id, "done"), 32'(done), 32'(exp_done));
    if (exp_done) void'(done_q[id].pop_front());
    check(tg(id, "busy"), 32'(busy), 32'(cyc >= busy_lo[id] && cyc <= busy_hi[id]));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, a_rd_en, 32'(a_rd_addr), a_wr_en, 32'(a_wr_addr), 32'(a_wr_data), a_done, a_busy);
      mon(1, b_rd_en, 32'(b_rd_addr), b_wr_en, 32'(b_wr_addr), 32'(b_wr_data), b_done, b_busy);
      mon(2, c_rd_en, 32'(c_rd_addr), c_wr_en, 32'(c_wr_addr), 32'(c_wr_data), c_done, c_busy);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    n_cmp   = 0;
    n_bad   = 0;
    mon_en  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      busy_lo[i] = 1;
      busy_hi[i] = 0;
    end
    rst_v   = 3'b000;
    start_v = 3'b000;
    tick(3);
    rst_v  = 3'b111;
    mon_en = 1'b1;

    // Reset state of the registered address and data ports.
    check("rst_a_rd_addr", 32'(a_rd_addr), 0);
    check("rst_a_wr_addr", 32'(a_wr_addr), 0);
    check("rst_a_wr_data", 32'(a_wr_data), 0);
    check("rst_c_rd_addr", 32'(c_rd_addr), 0);
    check("rst_c_wr_addr", 32'(c_wr_addr), 0);
    tick(2);

    // Basic passes on each geometry and latency.
    start_pass(0, t0);
    wait_idle(0);
    start_pass(1, t0);
    wait_idle(1);
    start_pass(2, t0);
    wait_idle(2);

    // start during READ (cycle 1) and during DONE is ignored.
    start_pass(0, t0);
    tick(1);
    start_v[0] = 1'b1;
    tick(1);
    start_v[0] = 1'b0;
    while (cyc < t0 + 6) tick(1);
    start_v[0] = 1'b1;
    tick(1);
    start_v[0] = 1'b0;
    wait_idle(0);
    tick(4);
    start_pass(0, t0);
    wait_idle(0);

    // Reset low during cycle 2 of a pass abandons it.
    start_pass(0, t0);
    tick(2);
    rst_v[0] = 1'b0;
    tick(1);
    rst_v[0] = 1'b1;
    rd_q[0].delete();
    wr_q[0].delete();
    done_q[0].delete();
    busy_hi[0] = t0 + 2;
    check("abort_rd_en",   32'(a_rd_en),   0);
    check("abort_wr_en",   32'(a_wr_en),   0);
    check("abort_busy",    32'(a_busy),    0);
    check("abort_done",    32'(a_done),    0);
    check("abort_rd_addr", 32'(a_rd_addr), 0);
    check("abort_wr_addr", 32'(a_wr_addr), 0);
    check("abort_wr_data", 32'(a_wr_data), 0);
    tick(8);
    start_pass(0, t0);
    wait_idle(0);

    // start held high: back-to-back passes, done every N+L+2 = 8 cycles.
    start_v[0] = 1'b1;
    t0 = cyc + 1;
    push_pass(0, t0);
    while (cyc < t0 + 7) tick(1);
    push_pass(0, cyc + 1);
    tick(1);
    start_v[0] = 1'b0;
    wait_idle(0);
    tick(4);

    for (int i = 0; i < 3; i++) begin
      check(tg(i, "leftover"), 32'(rd_q[i].size() + wr_q[i].size() + done_q[i].size()), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
